cta_dealloc_requester: RTL and testbench

- Initiator side of the resource-table dealloc interface.
- Collects workgroup-completion reports from CUs into a FIFO.
- Issues one dealloc command at a time to the resource table (dealloc valid, CU id, WG id), never in the same cycle as an alloc command.
- Waits for the matching dealloc-done, then reports the freed WG to the host interface over a valid/ready handshake.

---
 rtl/cta_dealloc_requester.sv | 182 ++++++++++++++++++
 tb/tb_cta_dealloc_requester.sv | 351 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cta_dealloc_requester.sv
// cta_dealloc_requester
// Initiator side of the resource-table dealloc interface. Buffers workgroup
// completion reports from the CUs, issues one dealloc command at a time to the
// resource table (yielding to alloc commands on the shared interface), waits
// for the matching dealloc-done, then reports the freed WG to the host.
//
// Ports:
//   clk, rst_n                      clock, synchronous active-low reset
//   cu_wg_done_valid_i/_ready_o     CU completion report handshake
//   cu_wg_done_cu_id_i/_wg_id_i     reporting CU / finished WG
//   dis_controller_wg_alloc_valid_i alloc command occupies the shared interface
//   dealloc_valid_o                 dealloc strobe (combinational)
//   dealloc_cu_id_o/_wg_id_o        dealloc command ids
//   grt_wg_dealloc_done_i           dealloc-done pulse from the resource table
//   grt_wg_dealloc_cu_id_i/_wg_id_i ids carried with the done pulse
//   host_wg_done_valid_o/_ready_i   freed-WG report handshake to the host
//   host_wg_done_cu_id_o/_wg_id_o   freed-WG report ids
//   busy_o                          work pending or in flight
//   err_mismatch_o, err_timeout_o   sticky error flags

module cta_dealloc_requester #(
    parameter int unsigned WG_ID_W    = 8,
    parameter int unsigned CU_ID_W    = 4,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned TIMEOUT    = 255
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               cu_wg_done_valid_i,
    output logic               cu_wg_done_ready_o,
    input  logic [CU_ID_W-1:0] cu_wg_done_cu_id_i,
    input  logic [WG_ID_W-1:0] cu_wg_done_wg_id_i,
    input  logic               dis_controller_wg_alloc_valid_i,
    output logic               dealloc_valid_o,
    output logic [CU_ID_W-1:0] dealloc_cu_id_o,
    output logic [WG_ID_W-1:0] dealloc_wg_id_o,
    input  logic               grt_wg_dealloc_done_i,
    input  logic [CU_ID_W-1:0] grt_wg_dealloc_cu_id_i,
    input  logic [WG_ID_W-1:0] grt_wg_dealloc_wg_id_i,
    output logic               host_wg_done_valid_o,
    input  logic               host_wg_done_ready_i,
    output logic [CU_ID_W-1:0] host_wg_done_cu_id_o,
    output logic [WG_ID_W-1:0] host_wg_done_wg_id_o,
    output logic               busy_o,
    output logic               err_mismatch_o,
    output logic               err_timeout_o
);

    localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned ENT_W = CU_ID_W + WG_ID_W;
    localparam int unsigned TMO_W = 16;

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ISSUE  = 2'd1;
    localparam logic [1:0] S_WAIT   = 2'd2;
    localparam logic [1:0] S_REPORT = 2'd3;

    logic [1:0]         state, state_nxt;
    logic [ENT_W-1:0]   fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr, rd_ptr;
    logic [CNT_W-1:0]   count, count_nxt;
    logic [CU_ID_W-1:0] cmd_cu;
    logic [WG_ID_W-1:0] cmd_wg;
    logic [TMO_W-1:0]   tmo_cnt, tmo_nxt, tmo_inc;
    logic               err_mm_q, err_mm_nxt;
    logic               err_to_q, err_to_nxt;
    logic               ready_q, busy_q, host_valid_q;
    logic               push, pop, done_match;

    assign push       = cu_wg_done_valid_i & ready_q;
    assign done_match = grt_wg_dealloc_done_i
                      & (grt_wg_dealloc_cu_id_i == cmd_cu)
                      & (grt_wg_dealloc_wg_id_i == cmd_wg);
    assign tmo_inc    = tmo_cnt + TMO_W'(1);

    // Next-state, FIFO pop and error decisions
    always_comb begin
        state_nxt  = state;
        pop        = 1'b0;
        tmo_nxt    = tmo_cnt;
        err_mm_nxt = err_mm_q;
        err_to_nxt = err_to_q;
        count_nxt  = count;

        case (state)
            S_IDLE: begin
                if (count != '0) begin
                    pop       = 1'b1;
                    state_nxt = S_ISSUE;
                end
            end
            S_ISSUE: begin
                // Alloc owns the shared id lines this cycle; hold the command.
                if (!dis_controller_wg_alloc_valid_i) begin
                    state_nxt = S_WAIT;
                    tmo_nxt   = '0;
                end
            end
            S_WAIT: begin
                if (done_match) begin
                    state_nxt = S_REPORT;
                end else if (tmo_inc == TMO_W'(TIMEOUT)) begin
                    state_nxt  = S_ISSUE;
                    err_to_nxt = 1'b1;
                end else begin
                    tmo_nxt = tmo_inc;
                end
            end
            S_REPORT: begin
                if (host_wg_done_ready_i) begin
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase

        // Any done that does not close the outstanding command is an error.
        if (grt_wg_dealloc_done_i && !((state == S_WAIT) && done_match)) begin
            err_mm_nxt = 1'b1;
        end

        case ({push, pop})
            2'b10:   count_nxt = count + CNT_W'(1);
            2'b01:   count_nxt = count - CNT_W'(1);
            default: count_nxt = count;
        endcase
    end

    // FIFO storage; contents are don't-care while the pointers are reset
    always_ff @(posedge clk) begin
        if (rst_n && push) begin
            fifo_mem[wr_ptr] <= {cu_wg_done_cu_id_i, cu_wg_done_wg_id_i};
        end
    end

    // State, pointers, command registers and registered outputs
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= S_IDLE;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            cmd_cu       <= '0;
            cmd_wg       <= '0;
            tmo_cnt      <= '0;
            err_mm_q     <= 1'b0;
            err_to_q     <= 1'b0;
            ready_q      <= 1'b1;
            busy_q       <= 1'b0;
            host_valid_q <= 1'b0;
        end else begin
            state    <= state_nxt;
            count    <= count_nxt;
            tmo_cnt  <= tmo_nxt;
            err_mm_q <= err_mm_nxt;
            err_to_q <= err_to_nxt;
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr           <= rd_ptr + PTR_W'(1);
                {cmd_cu, cmd_wg} <= fifo_mem[rd_ptr];
            end
            ready_q      <= (count_nxt != CNT_W'(FIFO_DEPTH));
            busy_q       <= (state_nxt != S_IDLE) || (count_nxt != '0);
            host_valid_q <= (state_nxt == S_REPORT);
        end
    end

    assign cu_wg_done_ready_o   = ready_q;
    assign dealloc_valid_o      = (state == S_ISSUE) & ~dis_controller_wg_alloc_valid_i;
    assign dealloc_cu_id_o      = cmd_cu;
    assign dealloc_wg_id_o      = cmd_wg;
    assign host_wg_done_valid_o = host_valid_q;
    assign host_wg_done_cu_id_o = cmd_cu;
    assign host_wg_done_wg_id_o = cmd_wg;
    assign busy_o               = busy_q;
    assign err_mismatch_o       = err_mm_q;
    assign err_timeout_o        = err_to_q;

endmodule

// File: tb/tb_cta_dealloc_requester.sv
// Bench for cta_dealloc_requester: per-cycle vector table for the single-WG
// and alloc-collision flows, then hand-written sequences for FIFO
// back-pressure, id mismatch, timeout re-issue and mid-operation reset.

module tb_cta_dealloc_requester;

    localparam int unsigned CW = 4;
    localparam int unsigned WW = 8;

    logic          clk;
    logic          rst_n;
    logic          cu_v;
    logic          cu_rdy;
    logic [CW-1:0] cu_cu;
    logic [WW-1:0] cu_wg;
    logic          alloc;
    logic          dv;
    logic [CW-1:0] d_cu;
    logic [WW-1:0] d_wg;
    logic          dn;
    logic [CW-1:0] dn_cu;
    logic [WW-1:0] dn_wg;
    logic          hv;
    logic          hr;
    logic [CW-1:0] h_cu;
    logic [WW-1:0] h_wg;
    logic          busy;
    logic          err_mm;
    logic          err_to;

    int checks   = 0;
    int failures = 0;

    cta_dealloc_requester #(
        .WG_ID_W   (WW),
        .CU_ID_W   (CW),
        .FIFO_DEPTH(4),
        .TIMEOUT   (10)
    ) dut (
        .clk                            (clk),
        .rst_n                          (rst_n),
        .cu_wg_done_valid_i             (cu_v),
        .cu_wg_done_ready_o             (cu_rdy),
        .cu_wg_done_cu_id_i             (cu_cu),
        .cu_wg_done_wg_id_i             (cu_wg),
        .dis_controller_wg_alloc_valid_i(alloc),
        .dealloc_valid_o                (dv),
        .dealloc_cu_id_o                (d_cu),
        .dealloc_wg_id_o                (d_wg),
        .grt_wg_dealloc_done_i          (dn),
        .grt_wg_dealloc_cu_id_i         (dn_cu),
        .grt_wg_dealloc_wg_id_i         (dn_wg),
        .host_wg_done_valid_o           (hv),
        .host_wg_done_ready_i           (hr),
        .host_wg_done_cu_id_o           (h_cu),
        .host_wg_done_wg_id_o           (h_wg),
        .busy_o                         (busy),
        .err_mismatch_o                 (err_mm),
        .err_timeout_o                  (err_to)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic          cv;
        logic [CW-1:0] ccu;
        logic [WW-1:0] cwg;
        logic          al;
        logic          dn;
        logic [CW-1:0] dcu;
        logic [WW-1:0] dwg;
        logic          hr;
        logic          e_dv;
        logic          e_hv;
        logic [CW-1:0] e_cu;
        logic [WW-1:0] e_wg;
        logic          e_busy;
        logic          e_rdy;
    } vec_t;

    vec_t vt[$];

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0b expected %0b", name, act, exp);
        end
    endtask

    task automatic chkv(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Advance to 1 time unit after the next rising edge (input drive point).
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_dv(output bit ok);
        ok = 1'b0;
        for (int w = 0; w < 100; w++) begin
            #1;
            if (dv === 1'b1) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
    endtask

    task automatic wait_hv(output bit ok);
        ok = 1'b0;
        for (int w = 0; w < 100; w++) begin
            #1;
            if (hv === 1'b1) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
    endtask

    task automatic push_one(input logic [CW-1:0] c, input logic [WW-1:0] g);
        cu_v  = 1'b1;
        cu_cu = c;
        cu_wg = g;
        tick();
        cu_v  = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        bit ok;
        int gap;

        rst_n = 1'b0; cu_v = 1'b0; cu_cu = '0; cu_wg = '0; alloc = 1'b0;
        dn = 1'b0; dn_cu = '0; dn_wg = '0; hr = 1'b0;
        tick(); tick(); tick();
        #1;
        chk1("reset ready", cu_rdy, 1'b1);
        chk1("reset dealloc_valid", dv, 1'b0);
        chk1("reset host_valid", hv, 1'b0);
        chk1("reset busy", busy, 1'b0);
        chk1("reset err_mismatch", err_mm, 1'b0);
        chk1("reset err_timeout", err_to, 1'b0);
        chkv("reset dealloc ids", 32'({d_cu, d_wg}), 32'd0);
        chkv("reset host ids", 32'({h_cu, h_wg}), 32'd0);
        rst_n = 1'b1;

        // Single WG (cycles 0-8) then alloc collision (cycles 9-18).
        //            cv    ccu   cwg    al    dn    dcu   dwg    hr    e_dv  e_hv  e_cu  e_wg   busy  rdy
        vt.push_back('{1'b1, 4'd1, 8'd5, 1'b0, 1'b0, 4'd0, 8'd0, 1'b0, 1'b0, 1'b0, 4'd0, 8'd0, 1'b0, 1'b1});
        vt.push_back('{1'b0, 4'd0, 8'd0, 1'b0, 1'b0, 4'd0, 8'd0, 1'b0, 1'b0, 1'b0, 4'd0, 8'd0, 1'b1, 1'b1});
        vt.push_back('{1'b0, 4'd0, 8'd0, 1'b0, 1'b0, 4'd0, 8'd0, 1'b0, 1'b1, 1'b0, 4'd1, 8'd5, 1'b1, 1'b1});
        vt.push_back('{1'b0, 4'd0, 8'd0, 1'b0, 1'b0, 4'd0, 8'd0, 1'b0, 1'b0, 1'b0, 4'd1, 8'd5, 1'b1, 1'b1});
        vt.push_back('{1'b0, 4'd0, 8'd0, 1'b0, 1'b0, 4'd0, 8'd0, 1'b0, 1'b0, 1'b0, 4'd1, 8'd5, 1'b1, 1'b1});
        vt.push_back('{1'b0, 4'd0, 8'd0, 1'b0, 1'b0, 4'd0, 8'd0, 1'b0, 1'b0, 1'b0, 4'd1, 8'd5, 1'b1, 1'b1});
        vt.push_back('{1'b0, 4'd0, 8'd0, 1'b0, 1'b1, 4'd1, 8'd5, 1'b0, 1'b0, 1'b0, 4'd1, 8'd5, 1'b1, 1'b1});
        vt.push_back('{1'b0, 4'd0, 8'd0, 1'b0, 1'b0, 4'd0, 8'd0, 1'b1, 1'b0, 1'b1, 4'd1, 8'd5, 1'b1, 1'b1});
        vt.push_back('{1'b0, 4'd0, 8'd0, 1'b0, 1'b0, 4'd0, 8'd0, 1'b0, 1'b0, 1'b0, 4'd1, 8'd5, 1'b0, 1'b1});
        vt.push_back('{1'b1, 4'd2, 8'd7, 1'b0, 1'b0, 4'd0, 8'd0, 1'b0, 1'b0, 1'b0, 4'd1, 8'd5, 1'b0, 1'b1});
        vt.push_back('{1'b0, 4'd0, 8'd0, 1'b0, 1'b0, 4'd0, 8'd0, 1'b0, 1'b0, 1'b0, 4'd1, 8'd5, 1'b1, 1'b1});
        vt.push_back('{1'b0, 4'd0, 8'd0, 1'b1, 1'b0, 4'd0, 8'd0, 1'b0, 1'b0, 1'b0, 4'd2, 8'd7, 1'b1, 1'b1});
        vt.push_back('{1'b0, 4'd0, 8'd0, 1'b1, 1'b0, 4'd0, 8'd0, 1'b0, 1'b0, 1'b0, 4'd2, 8'd7, 1'b1, 1'b1});
        vt.push_back('{1'b0, 4'd0, 8'd0, 1'b1, 1'b0, 4'd0, 8'd0, 1'b0, 1'b0, 1'b0, 4'd2, 8'd7, 1'b1, 1'b1});
        vt.push_back('{1'b0, 4'd0, 8'd0, 1'b0, 1'b0, 4'd0, 8'd0, 1'b0, 1'b1, 1'b0, 4'd2, 8'd7, 1'b1, 1'b1});
        vt.push_back('{1'b0, 4'd0, 8'd0, 1'b0, 1'b0, 4'd0, 8'd0, 1'b0, 1'b0, 1'b0, 4'd2, 8'd7, 1'b1, 1'b1});
        vt.push_back('{1'b0, 4'd0, 8'd0, 1'b0, 1'b1, 4'd2, 8'd7, 1'b0, 1'b0, 1'b0, 4'd2, 8'd7, 1'b1, 1'b1});
        vt.push_back('{1'b0, 4'd0, 8'd0, 1'b0, 1'b0, 4'd0, 8'd0, 1'b1, 1'b0, 1'b1, 4'd2, 8'd7, 1'b1, 1'b1});
        vt.push_back('{1'b0, 4'd0, 8'd0, 1'b0, 1'b0, 4'd0, 8'd0, 1'b0, 1'b0, 1'b0, 4'd2, 8'd7, 1'b0, 1'b1});

        foreach (vt[i]) begin
            tick();
            cu_v = vt[i].cv; cu_cu = vt[i].ccu; cu_wg = vt[i].cwg; alloc = vt[i].al;
            dn = vt[i].dn; dn_cu = vt[i].dcu; dn_wg = vt[i].dwg; hr = vt[i].hr;
            #1;
            chk1($sformatf("vec%0d dealloc_valid", i), dv, vt[i].e_dv);
            chkv($sformatf("vec%0d dealloc ids", i), 32'({d_cu, d_wg}), 32'({vt[i].e_cu, vt[i].e_wg}));
            chk1($sformatf("vec%0d host_valid", i), hv, vt[i].e_hv);
            if (vt[i].e_hv) begin
                chkv($sformatf("vec%0d host ids", i), 32'({h_cu, h_wg}), 32'({vt[i].e_cu, vt[i].e_wg}));
            end
            chk1($sformatf("vec%0d busy", i), busy, vt[i].e_busy);
            chk1($sformatf("vec%0d ready", i), cu_rdy, vt[i].e_rdy);
            chk1($sformatf("vec%0d err_mismatch", i), err_mm, 1'b0);
        end
        cu_v = 1'b0; alloc = 1'b0; dn = 1'b0; hr = 1'b0;
        tick();

        // Back-pressure: six reports, host holds ready low, in-order delivery.
        fork
            begin
                bit pok;
                for (int k = 0; k < 6; k++) begin
                    cu_v  = 1'b1;
                    cu_cu = CW'(k);
                    cu_wg = WW'(16 + k);
                    pok   = 1'b0;
                    for (int w = 0; w < 200; w++) begin
                        #1;
                        if (w == 0) begin
                            chk1($sformatf("fifo ready at push%0d", k), cu_rdy, (k < 5) ? 1'b1 : 1'b0);
                        end
                        if (cu_rdy === 1'b1) pok = 1'b1;
                        tick();
                        if (pok) break;
                    end
                    chk1($sformatf("fifo push%0d accepted", k), pok, 1'b1);
                end
                cu_v = 1'b0;
            end
            begin
                bit rok;
                for (int k = 0; k < 6; k++) begin
                    wait_dv(rok);
                    chk1($sformatf("fifo dealloc%0d seen", k), rok, 1'b1);
                    chkv($sformatf("fifo dealloc%0d ids", k), 32'({d_cu, d_wg}), 32'({CW'(k), WW'(16 + k)}));
                    tick();
                    dn = 1'b1; dn_cu = CW'(k); dn_wg = WW'(16 + k);
                    tick();
                    dn = 1'b0;
                    wait_hv(rok);
                    chk1($sformatf("fifo report%0d seen", k), rok, 1'b1);
                    for (int h = 0; h < 2; h++) begin
                        chk1($sformatf("fifo report%0d held", k), hv, 1'b1);
                        chkv($sformatf("fifo report%0d ids", k), 32'({h_cu, h_wg}), 32'({CW'(k), WW'(16 + k)}));
                        tick();
                        #1;
                    end
                    chk1($sformatf("fifo report%0d still held", k), hv, 1'b1);
                    hr = 1'b1;
                    tick();
                    hr = 1'b0;
                end
            end
        join
        tick();
        #1;
        chk1("fifo drained busy", busy, 1'b0);
        chk1("fifo drained err_mismatch", err_mm, 1'b0);
        chk1("fifo drained err_timeout", err_to, 1'b0);
        tick();

        // Mismatching done is flagged and does not complete the command.
        push_one(4'd2, 8'd9);
        wait_dv(ok);
        chk1("mm dealloc seen", ok, 1'b1);
        chkv("mm dealloc ids", 32'({d_cu, d_wg}), 32'({4'd2, 8'd9}));
        tick();
        dn = 1'b1; dn_cu = 4'd2; dn_wg = 8'd8;
        tick();
        dn = 1'b0;
        #1;
        chk1("mm err_mismatch set", err_mm, 1'b1);
        chk1("mm no report", hv, 1'b0);
        chk1("mm no reissue", dv, 1'b0);
        chk1("mm busy", busy, 1'b1);
        dn = 1'b1; dn_cu = 4'd2; dn_wg = 8'd9;
        tick();
        dn = 1'b0;
        #1;
        chk1("mm report valid", hv, 1'b1);
        chkv("mm report ids", 32'({h_cu, h_wg}), 32'({4'd2, 8'd9}));
        hr = 1'b1;
        tick();
        hr = 1'b0;
        #1;
        chk1("mm back to idle", busy, 1'b0);
        tick();

        // Timeout: re-issue of the same command 11 cycles after the first strobe.
        push_one(4'd3, 8'd4);
        wait_dv(ok);
        chk1("tmo first dealloc seen", ok, 1'b1);
        chk1("tmo err_timeout before", err_to, 1'b0);
        gap = 0;
        for (int j = 1; j <= 30; j++) begin
            tick();
            #1;
            if (j == 10) chk1("tmo err_timeout last wait cycle", err_to, 1'b0);
            if (dv === 1'b1) begin
                gap = j;
                break;
            end
        end
        chkv("tmo reissue gap", 32'(gap), 32'd11);
        chk1("tmo err_timeout set", err_to, 1'b1);
        chkv("tmo reissue ids", 32'({d_cu, d_wg}), 32'({4'd3, 8'd4}));
        tick();
        dn = 1'b1; dn_cu = 4'd3; dn_wg = 8'd4;
        tick();
        dn = 1'b0;
        #1;
        chk1("tmo report valid", hv, 1'b1);
        hr = 1'b1;
        tick();
        hr = 1'b0;

        // Reset in WAIT_DONE with two entries queued.
        cu_v = 1'b1; cu_cu = 4'd5; cu_wg = 8'd1;
        tick();
        cu_wg = 8'd2;
        tick();
        cu_wg = 8'd3;
        tick();
        cu_v = 1'b0;
        #1;
        chk1("rst pre busy", busy, 1'b1);
        chk1("rst pre err_mismatch", err_mm, 1'b1);
        chk1("rst pre err_timeout", err_to, 1'b1);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        #1;
        chk1("rst dealloc_valid", dv, 1'b0);
        chk1("rst host_valid", hv, 1'b0);
        chk1("rst ready", cu_rdy, 1'b1);
        chk1("rst busy", busy, 1'b0);
        chk1("rst err_mismatch", err_mm, 1'b0);
        chk1("rst err_timeout", err_to, 1'b0);
        dn = 1'b1; dn_cu = 4'd5; dn_wg = 8'd1;
        tick();
        dn = 1'b0;
        #1;
        chk1("late done err_mismatch", err_mm, 1'b1);
        chk1("late done busy", busy, 1'b0);
        chk1("late done no report", hv, 1'b0);
        for (int j = 0; j < 4; j++) begin
            tick();
            #1;
            chk1($sformatf("post reset idle dv%0d", j), dv, 1'b0);
            chk1($sformatf("post reset idle busy%0d", j), busy, 1'b0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
